// File: rtl/ex_div_if.sv
// EX-stage divider handshake: operand request from EX control, status and results back.
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             annul;
    logic             busy;
    logic             ready;
    logic             stall_req;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    modport master (
        output start, signed_div, opa, opb, annul,
        input  busy, ready, stall_req, quot, rem
    );

    modport slave (
        input  start, signed_div, opa, opb, annul,
        output busy, ready, stall_req, quot, rem
    );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// Works on operand magnitudes and applies the sign fix-up when the last iteration retires.
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_div_if.slave    div
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               sign_q_reg, sign_r_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic [2*WIDTH:0]   work_reg;
    logic [WIDTH-1:0]   quot_reg, rem_reg;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH:0]   shifted, iter_work;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   iter_q, iter_r;
    logic               last_iter;

    assign abs_a = (div.signed_div && div.opa[WIDTH-1]) ? -div.opa : div.opa;
    assign abs_b = (div.signed_div && div.opb[WIDTH-1]) ? -div.opb : div.opb;

    // One restoring step: the trial difference is negative exactly when its MSB is set,
    // because the partial remainder is always below twice the divisor.
    assign shifted   = work_reg << 1;
    assign diff      = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_reg};
    assign iter_work = diff[WIDTH] ? shifted : {diff, shifted[WIDTH-1:1], 1'b1};
    assign iter_q    = iter_work[WIDTH-1:0];
    assign iter_r    = iter_work[2*WIDTH-1:WIDTH];
    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (div.start) begin
                    state_next = (div.opb == '0) ? BY_ZERO : ON;
                end
            end
            BY_ZERO: state_next = END;
            ON: begin
                if (last_iter) begin
                    state_next = END;
                end
            end
            END: begin
                if (!div.start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (div.annul) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
            divisor_reg <= '0;
            work_reg    <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (div.annul) begin
                cnt_reg  <= '0;
                quot_reg <= '0;
                rem_reg  <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (div.start && div.opb != '0) begin
                            sign_q_reg  <= div.signed_div & (div.opa[WIDTH-1] ^ div.opb[WIDTH-1]);
                            sign_r_reg  <= div.signed_div & div.opa[WIDTH-1];
                            divisor_reg <= abs_b;
                            work_reg    <= {{(WIDTH+1){1'b0}}, abs_a};
                            cnt_reg     <= '0;
                        end
                    end
                    BY_ZERO: begin
                        quot_reg <= '0;
                        rem_reg  <= '0;
                    end
                    ON: begin
                        work_reg <= iter_work;
                        cnt_reg  <= cnt_reg + 1'b1;
                        if (last_iter) begin
                            quot_reg <= sign_q_reg ? -iter_q : iter_q;
                            rem_reg  <= sign_r_reg ? -iter_r : iter_r;
                        end
                    end
                    END: begin
                        if (!div.start) begin
                            quot_reg <= '0;
                            rem_reg  <= '0;
                        end
                    end
                    default: begin
                        quot_reg <= '0;
                        rem_reg  <= '0;
                    end
                endcase
            end
        end
    end

    assign div.busy      = (state_reg == BY_ZERO) || (state_reg == ON);
    assign div.ready     = (state_reg == END);
    assign div.stall_req = div.start & ~div.ready;
    assign div.quot      = quot_reg;
    assign div.rem       = rem_reg;
endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit: latency, signed/unsigned results,
// divide-by-zero, annul, asynchronous reset and back-to-back operation.
module tb_ex_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks_total  = 0;
    int   checks_passed = 0;

    always #5 clk = ~clk;

    ex_div_if #(.WIDTH(32)) dif ();

    ex_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .div (dif.slave)
    );

    // Raise start with the given operands and count edges (sampling edge included)
    // until ready; edges = 0 means the bound expired. start is left high.
    task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          output int edges);
        dif.start      = 1'b1;
        dif.signed_div = sd;
        dif.opa        = a;
        dif.opb        = b;
        edges          = 0;
        for (int i = 1; i <= 60 && edges == 0; i++) begin
            @(posedge clk); #1;
            if (dif.ready) edges = i;
        end
    endtask

    task automatic end_div();
        dif.start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        dif.start = 1'b0; dif.signed_div = 1'b0; dif.annul = 1'b0;
        dif.opa = '0; dif.opb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks_total++;
        if ({dif.busy, dif.ready, dif.stall_req} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {dif.busy, dif.ready, dif.stall_req});
        else checks_passed++;
        checks_total++;
        if ({dif.quot, dif.rem} !== 64'h0) $display("FAIL reset_results: got q=%h r=%h want 0/0", dif.quot, dif.rem);
        else checks_passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic();
        int edges = 0;
        int stall_cycles = 0;
        dif.start = 1'b1; dif.signed_div = 1'b0; dif.opa = 32'd100; dif.opb = 32'd7;
        #1;
        if (dif.stall_req) stall_cycles++;
        for (int i = 1; i <= 60 && edges == 0; i++) begin
            @(posedge clk); #1;
            if (dif.ready) edges = i;
            else if (dif.stall_req) stall_cycles++;
        end
        $display("divu 100 / 7 -> q=%0d r=%0d edges=%0d stall=%0d", dif.quot, dif.rem, edges, stall_cycles);
        checks_total++;
        if (edges !== 33) $display("FAIL divu_latency: got %0d edges want 33", edges);
        else checks_passed++;
        checks_total++;
        if (stall_cycles !== 33) $display("FAIL divu_stall_cycles: got %0d want 33", stall_cycles);
        else checks_passed++;
        checks_total++;
        if ({dif.stall_req, dif.busy} !== 2'b00) $display("FAIL divu_end_flags: got stall/busy=%b want 00", {dif.stall_req, dif.busy});
        else checks_passed++;
        checks_total++;
        if (dif.quot !== 32'd14 || dif.rem !== 32'd2) $display("FAIL divu_result: got q=%0d r=%0d want 14/2", dif.quot, dif.rem);
        else checks_passed++;
        // Hold in END while start stays high; operand changes are ignored.
        dif.opa = 32'd5;
        @(posedge clk); #1;
        checks_total++;
        if (dif.ready !== 1'b1 || dif.quot !== 32'd14 || dif.rem !== 32'd2)
            $display("FAIL divu_hold: got ready=%b q=%0d r=%0d want 1/14/2", dif.ready, dif.quot, dif.rem);
        else checks_passed++;
        end_div();
        checks_total++;
        if (dif.ready !== 1'b0 || dif.quot !== 32'd0 || dif.rem !== 32'd0)
            $display("FAIL divu_release: got ready=%b q=%h r=%h want 0/0/0", dif.ready, dif.quot, dif.rem);
        else checks_passed++;
    endtask

    task automatic test_signed_and_bounds();
        logic        sd [6];
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] vq [6];
        logic [31:0] vr [6];
        int edges;
        sd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        va = '{32'hFFFFFF9C, 32'd100, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        vb = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd1, 32'h00010000, 32'hFFFFFFFF};
        vq = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0};
        vr = '{32'hFFFFFFFE, 32'd2, 32'h0, 32'h0, 32'h0000FFFF, 32'h80000000};
        for (int i = 0; i < 6; i++) begin
            do_div(sd[i], va[i], vb[i], edges);
            $display("div%s %h / %h -> q=%h r=%h edges=%0d", sd[i] ? "" : "u", va[i], vb[i], dif.quot, dif.rem, edges);
            checks_total++;
            if (edges !== 33) $display("FAIL vec%0d_latency: got %0d edges want 33", i, edges);
            else checks_passed++;
            checks_total++;
            if (dif.quot !== vq[i] || dif.rem !== vr[i])
                $display("FAIL vec%0d_result: got q=%h r=%h want q=%h r=%h", i, dif.quot, dif.rem, vq[i], vr[i]);
            else checks_passed++;
            end_div();
        end
    endtask

    task automatic test_div_by_zero();
        int edges;
        do_div(1'b1, 32'd123, 32'd0, edges);
        $display("div 123 / 0 -> q=%h r=%h edges=%0d", dif.quot, dif.rem, edges);
        checks_total++;
        if (edges !== 2) $display("FAIL divzero_latency: got %0d edges want 2", edges);
        else checks_passed++;
        checks_total++;
        if (dif.quot !== 32'd0 || dif.rem !== 32'd0) $display("FAIL divzero_result: got q=%h r=%h want 0/0", dif.quot, dif.rem);
        else checks_passed++;
        end_div();
    endtask

    task automatic test_annul();
        int edges;
        dif.start = 1'b1; dif.signed_div = 1'b0; dif.opa = 32'd1000; dif.opb = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        // Edge 12 from start is the iteration with cnt == 10.
        dif.annul = 1'b1; dif.start = 1'b0;
        @(posedge clk); #1;
        dif.annul = 1'b0;
        $display("divu 1000 / 3 annulled -> busy=%b ready=%b q=%h r=%h", dif.busy, dif.ready, dif.quot, dif.rem);
        checks_total++;
        if ({dif.busy, dif.ready} !== 2'b00 || dif.quot !== 32'd0 || dif.rem !== 32'd0)
            $display("FAIL annul_abort: got busy/ready=%b q=%h r=%h want 00/0/0", {dif.busy, dif.ready}, dif.quot, dif.rem);
        else checks_passed++;
        @(posedge clk); #1;
        checks_total++;
        if (dif.ready !== 1'b0) $display("FAIL annul_idle: got ready=%b want 0", dif.ready);
        else checks_passed++;
        do_div(1'b0, 32'd1000, 32'd3, edges);
        $display("divu 1000 / 3 -> q=%0d r=%0d edges=%0d", dif.quot, dif.rem, edges);
        checks_total++;
        if (edges !== 33 || dif.quot !== 32'd333 || dif.rem !== 32'd1)
            $display("FAIL annul_restart: got edges=%0d q=%0d r=%0d want 33/333/1", edges, dif.quot, dif.rem);
        else checks_passed++;
        end_div();
    endtask

    task automatic test_async_rst_and_operands();
        int edges = 0;
        dif.start = 1'b1; dif.signed_div = 1'b0; dif.opa = 32'd1000; dif.opb = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        checks_total++;
        if (dif.busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", dif.busy);
        else checks_passed++;
        #2 rst = 1'b1;
        #1;
        $display("async rst mid-ON -> busy=%b ready=%b q=%h r=%h", dif.busy, dif.ready, dif.quot, dif.rem);
        checks_total++;
        if ({dif.busy, dif.ready} !== 2'b00 || dif.quot !== 32'd0 || dif.rem !== 32'd0)
            $display("FAIL rst_async: got busy/ready=%b q=%h r=%h want 00/0/0", {dif.busy, dif.ready}, dif.quot, dif.rem);
        else checks_passed++;
        dif.start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        dif.start = 1'b1; dif.signed_div = 1'b1; dif.opa = 32'hFFFFFF9C; dif.opb = 32'd7;
        @(posedge clk); #1;
        dif.opa = 32'h12345678; dif.opb = 32'd0;
        for (int i = 2; i <= 60 && edges == 0; i++) begin
            @(posedge clk); #1;
            if (i == 10) dif.opb = 32'hDEADBEEF;
            if (dif.ready) edges = i;
        end
        $display("div -100 / 7 with operand churn -> q=%h r=%h edges=%0d", dif.quot, dif.rem, edges);
        checks_total++;
        if (edges !== 33 || dif.quot !== 32'hFFFFFFF2 || dif.rem !== 32'hFFFFFFFE)
            $display("FAIL operand_churn: got edges=%0d q=%h r=%h want 33/fffffff2/fffffffe", edges, dif.quot, dif.rem);
        else checks_passed++;
        end_div();
    endtask

    task automatic test_back_to_back();
        int edges;
        do_div(1'b0, 32'd7, 32'd2, edges);
        $display("divu 7 / 2 -> q=%h r=%h edges=%0d", dif.quot, dif.rem, edges);
        checks_total++;
        if (edges !== 33 || dif.quot !== 32'd3 || dif.rem !== 32'd1)
            $display("FAIL b2b_first: got edges=%0d q=%h r=%h want 33/3/1", edges, dif.quot, dif.rem);
        else checks_passed++;
        end_div();
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, edges);
        $display("div -7 / 2 -> q=%h r=%h edges=%0d", dif.quot, dif.rem, edges);
        checks_total++;
        if (edges !== 33 || dif.quot !== 32'hFFFFFFFD || dif.rem !== 32'hFFFFFFFF)
            $display("FAIL b2b_second: got edges=%0d q=%h r=%h want 33/fffffffd/ffffffff", edges, dif.quot, dif.rem);
        else checks_passed++;
        end_div();
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed_and_bounds();
        test_div_by_zero();
        test_annul();
        test_async_rst_and_operands();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
